// File: rtl/axi_rd_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : axi_pkg
// Brief    : AXI burst/response encodings and read-responder state type.
// Revision : 1.0
// ----------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    BURST = 2'b10
  } rd_state_t;

  // Only power-of-two beat counts form a legal wrap window.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : axi_rd_responder_if
// Brief     : AXI4 read address/data channels (AR/R).
// Revision  : 1.0
// ----------------------------------------------------------------------------
interface axi_rd_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_burst_addr_gen
// Brief    : Combinational next-beat address for FIXED/INCR/WRAP 8-byte beats.
// Revision : 1.0
// ----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  wire [ADDR_WIDTH-1:0] i_addr,
  input  wire [7:0]            i_len,
  input  axi_burst_t           i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic                  w_unused;

  assign w_unused = ^i_addr[2:0];

  always_comb begin
    w_aligned = {i_addr[ADDR_WIDTH-1:3], 3'b000};
    w_incr    = w_aligned + ADDR_WIDTH'(8);
    // Window size minus one is (len+1)*8-1, i.e. {len, 3'b111}.
    w_mask    = ADDR_WIDTH'({i_len, 3'b111});
    case (i_burst)
      FIXED:   o_next_addr = w_aligned;
      WRAP:    o_next_addr = wrap_len_ok(i_len) ? ((w_aligned & ~w_mask) | (w_incr & w_mask))
                                                : w_incr;
      default: o_next_addr = w_incr;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_rd_responder
// Brief    : AXI4 AR/R slave over a 64-bit word array with a backdoor write port.
//            Define RD_RANGE_CHECK_EN to answer out-of-array beats with SLVERR.
// Revision : 1.0
// ----------------------------------------------------------------------------
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH    = 13,
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    LATENCY     = 2
) (
  input  wire                  clk,
  input  wire                  reset,
  axi_rd_responder_if.slave    s_axi,
  input  wire                  bd_we,
  input  wire [ADDR_WIDTH-1:0] bd_addr,
  input  wire [DATA_WIDTH-1:0] bd_wdata
);
  // DEPTH_WORDS is a power of two so the index wraps by truncation.
  localparam int c_IDX_W = $clog2(DEPTH_WORDS);
  localparam int c_LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  rd_state_t             r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  axi_burst_t            r_burst;
  logic                  r_err;
  logic [c_LAT_W-1:0]    r_wait;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  axi_resp_t             r_rresp;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_hs_ar;
  logic                  w_hs_r;
  logic                  w_ar_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [ID_WIDTH-1:0]   w_beat_id;
  logic                  w_beat_last;
  logic                  w_beat_err;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_oor;
  logic                  w_slverr;
  logic                  w_present;
  logic [ADDR_WIDTH-1:0] w_bd_off;
  logic                  w_unused;

  assign w_hs_ar  = s_axi.s_axi_arvalid && r_arready;
  assign w_hs_r   = r_rvalid && s_axi.s_axi_rready;
  assign w_ar_err = (s_axi.s_axi_arsize != AXI_SIZE_8B) || (s_axi.s_axi_arburst == RSVD);
  assign w_bd_off = bd_addr - BASE_ADDR;
  assign w_unused = ^{w_bd_off, w_off, w_beat_addr[2:0]};

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Select the beat about to be registered onto the R channel.
  always_comb begin
    w_beat_addr = w_next_addr;
    w_beat_id   = r_id;
    w_beat_last = (r_cnt == 8'd1);
    w_beat_err  = r_err;
    case (r_state)
      IDLE: begin
        w_beat_addr = s_axi.s_axi_araddr;
        w_beat_id   = s_axi.s_axi_arid;
        w_beat_last = (s_axi.s_axi_arlen == 8'd0);
        w_beat_err  = w_ar_err;
      end
      WAIT: begin
        w_beat_addr = r_addr;
        w_beat_last = (r_cnt == 8'd0);
      end
      default: ;
    endcase
    w_aligned = {w_beat_addr[ADDR_WIDTH-1:3], 3'b000};
    w_off     = w_aligned - BASE_ADDR;
    w_idx     = w_off[c_IDX_W+2:3];
    w_oor     = 1'b0;
`ifdef RD_RANGE_CHECK_EN
    w_oor     = (w_aligned < BASE_ADDR) || (w_off >= (ADDR_WIDTH'(DEPTH_WORDS) << 3));
`endif
    w_slverr  = w_beat_err || w_oor;
    w_present = ((r_state == IDLE)  && w_hs_ar && (LATENCY == 0)) ||
                ((r_state == WAIT)  && (r_wait == '0)) ||
                ((r_state == BURST) && w_hs_r && !r_rlast);
  end

  always_ff @(posedge clk) begin
    if (bd_we) begin
      r_mem[w_bd_off[c_IDX_W+2:3]] <= bd_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= OKAY;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= FIXED;
      r_err     <= 1'b0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs_ar) begin
            r_arready <= 1'b0;
            r_id      <= s_axi.s_axi_arid;
            r_addr    <= s_axi.s_axi_araddr;
            r_len     <= s_axi.s_axi_arlen;
            r_cnt     <= s_axi.s_axi_arlen;
            r_burst   <= axi_burst_t'(s_axi.s_axi_arburst);
            r_err     <= w_ar_err;
            r_wait    <= c_LAT_W'(LATENCY - 1);
            r_state   <= (LATENCY == 0) ? BURST : WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_wait == '0) begin
            r_state <= BURST;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        BURST: begin
          if (w_hs_r) begin
            if (r_rlast) begin
              r_state   <= IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_present) begin
        r_rvalid <= 1'b1;
        r_rid    <= w_beat_id;
        r_rlast  <= w_beat_last;
        r_rresp  <= w_slverr ? SLVERR : OKAY;
        r_rdata  <= w_slverr ? '0 : r_mem[w_idx];
      end
    end
  end

  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rlast   = r_rlast;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rid     = r_rid;
  assign s_axi.s_axi_rdata   = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_axi_rd_responder
// Brief    : Directed and random AR/R bursts against an address-list memory model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_axi_rd_responder;
  localparam int          ID_W  = 13;
  localparam int          AW    = 64;
  localparam int          DW    = 64;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h0;
`ifdef RD_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_wdata = '0;

  axi_rd_responder_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_rd_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_axi    (axi),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata)
  );

  always #5 clk = ~clk;

  logic [63:0] m_mem [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] nx_id;
  logic [63:0] nx_addr;
  logic [7:0]  nx_len;
  logic [2:0]  nx_size;
  logic [1:0]  nx_burst;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, from the burst rules expressed arithmetically.
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input int len,
                                            input logic [1:0] burst, input int i);
    logic [63:0] a0, w, base;
    a0 = start & ~64'h7;
    if (burst == 2'b00) return a0;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      w    = 64'((len + 1) * 8);
      base = a0 - (a0 % w);
      return base + ((a0 - base + 64'(8 * i)) % w);
    end
    return a0 + 64'(8 * i);
  endfunction

  function automatic logic beat_err(input logic [2:0] size, input logic [1:0] burst,
                                    input logic [63:0] a);
    logic oor;
    oor = (a < BASE) || (a >= BASE + 64'(DEPTH * 8));
    return (size != 3'd3) || (burst == 2'b11) || (RANGE_CHK && oor);
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] a);
    return m_mem[int'(((a - BASE) >> 3) % 64'(DEPTH))];
  endfunction

  // Called and returns at a negedge. rmode: 0 always ready, 1 pattern 1,0,0, 2 random.
  task automatic run_burst(input string tag, input logic [12:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int rmode, input bit b2b, input int abort_at);
    int          k, b, guard, rpat;
    logic [63:0] a;
    logic        err, rr;
    axi.s_axi_arid    = id;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = len;
    axi.s_axi_arsize  = size;
    axi.s_axi_arburst = burst;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b0;
    guard = 0;
    while (!axi.s_axi_arready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ":arready"}, axi.s_axi_arready, 1'b1);
    @(negedge clk);
    if (b2b) begin
      axi.s_axi_arid    = nx_id;
      axi.s_axi_araddr  = nx_addr;
      axi.s_axi_arlen   = nx_len;
      axi.s_axi_arsize  = nx_size;
      axi.s_axi_arburst = nx_burst;
    end else begin
      axi.s_axi_arvalid = 1'b0;
    end
    check({tag, ":arready_drop"}, axi.s_axi_arready, 1'b0);
    k = 1;
    while (!axi.s_axi_rvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ":first_rvalid_cycle"}, 64'(k), 64'(1 + LAT));
    b = 0; rpat = 0; guard = 0;
    while (b <= int'(len) && guard < 400) begin
      a   = beat_addr(addr, int'(len), burst, b);
      err = beat_err(size, burst, a);
      if (b == abort_at) begin
        check({tag, ":pre_abort_rvalid"}, axi.s_axi_rvalid, 1'b1);
        #2 reset = 1'b0;
        #1 check({tag, ":async_rvalid"}, axi.s_axi_rvalid, 1'b0);
        check({tag, ":async_arready"}, axi.s_axi_arready, 1'b0);
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check({tag, ":arready_at_release"}, axi.s_axi_arready, 1'b0);
        @(negedge clk);
        check({tag, ":arready_after_release"}, axi.s_axi_arready, 1'b1);
        for (int j = 0; j < 4; j++) begin
          check({tag, ":no_beat_after_abort"}, axi.s_axi_rvalid, 1'b0);
          @(negedge clk);
        end
        return;
      end
      check({tag, ":rvalid"}, axi.s_axi_rvalid, 1'b1);
      check({tag, ":rid"},    axi.s_axi_rid, id);
      check({tag, ":rresp"},  axi.s_axi_rresp, err ? 2'b10 : 2'b00);
      check({tag, ":rdata"},  axi.s_axi_rdata, err ? 64'h0 : model_word(a));
      check({tag, ":rlast"},  axi.s_axi_rlast, (b == int'(len)));
      check({tag, ":arready_busy"}, axi.s_axi_arready, 1'b0);
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = (rpat % 3 == 0);
        default: rr = 1'($urandom % 2);
      endcase
      rpat++;
      axi.s_axi_rready = rr;
      if (rr) b++;
      @(negedge clk);
      guard++;
    end
    check({tag, ":beats_delivered"}, 64'(b), 64'(int'(len) + 1));
    check({tag, ":rvalid_after_last"}, axi.s_axi_rvalid, 1'b0);
    check({tag, ":arready_reopen"}, axi.s_axi_arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0;
    axi.s_axi_arsize = 3'd3; axi.s_axi_arburst = 2'b01;
    axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    reset = 1'b0;

    // Preload every word through the backdoor while reset is held.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bd_we    = 1'b1;
      bd_addr  = 64'(i * 8) | 64'($urandom_range(0, 7));
      bd_wdata = {$urandom, $urandom};
      m_mem[i] = bd_wdata;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bd_addr  = 64'h1000 + 64'(8 * i);
      bd_wdata = bd_addr >> 3;
      m_mem[int'(bd_addr >> 3)] = bd_wdata;
    end
    @(negedge clk);
    bd_we = 1'b0;

    check("rst:arready", axi.s_axi_arready, 1'b0);
    check("rst:rvalid",  axi.s_axi_rvalid, 1'b0);
    check("rst:rlast",   axi.s_axi_rlast, 1'b0);
    check("rst:rresp",   axi.s_axi_rresp, 2'b00);
    check("rst:rid",     axi.s_axi_rid, 13'h0);
    check("rst:rdata",   axi.s_axi_rdata, 64'h0);

    reset = 1'b1;
    #1 check("rel:arready_before_edge", axi.s_axi_arready, 1'b0);
    @(negedge clk);
    check("rel:arready_first_edge", axi.s_axi_arready, 1'b1);

    run_burst("wrap_fetch", 13'd5, 64'h1010, 8'd7, 3'd3, 2'b10, 0, 1'b0, -1);
    run_burst("incr_bp",    13'd9, 64'h2000, 8'd3, 3'd3, 2'b01, 1, 1'b0, -1);
    run_burst("err_size",   13'd1, 64'h3000, 8'd1, 3'd2, 2'b01, 0, 1'b0, -1);
    run_burst("err_burst",  13'd2, 64'h3000, 8'd1, 3'd3, 2'b11, 0, 1'b0, -1);
    run_burst("range_top",  13'd3, BASE + 64'(DEPTH * 8) - 64'd8, 8'd1, 3'd3, 2'b01, 0, 1'b0, -1);
    run_burst("fixed",      13'd4, 64'h0100, 8'd3, 3'd3, 2'b00, 2, 1'b0, -1);
    run_burst("wrap_len2",  13'd11, 64'h0208, 8'd2, 3'd3, 2'b10, 0, 1'b0, -1);
    run_burst("abort",      13'd6, 64'h1000, 8'd7, 3'd3, 2'b01, 0, 1'b0, 2);
    run_burst("post_abort", 13'd7, 64'h1020, 8'd7, 3'd3, 2'b10, 0, 1'b0, -1);

    nx_id = 13'h1abc; nx_addr = 64'h0500; nx_len = 8'd3; nx_size = 3'd3; nx_burst = 2'b10;
    run_burst("b2b_first",  13'd8, 64'h0400, 8'd3, 3'd3, 2'b01, 2, 1'b1, -1);
    run_burst("b2b_second", nx_id, nx_addr, nx_len, nx_size, nx_burst, 0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      ra = 64'($urandom_range(0, DEPTH * 8 + 256));
      rl = 8'($urandom_range(0, 15));
      rs = ($urandom % 8 == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      rb = 2'($urandom % 4);
      run_burst("random", 13'($urandom), ra, rl, rs, rb, int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
